xtea_iter_ctrl: RTL and testbench

Iterative XTEA engine controller. It sequences one shared XTEA full-round datapath (both half-rounds per clock) over ROUNDS clocks per block, for both encryption and decryption. Blocks enter and leave through valid/ready handshakes. It is the area-reduced counterpart of the fully unrolled pipelined xtea core and sits between the bus-side block buffer and the cipher output FIFO.

---
 rtl/xtea_iter_ctrl.sv | 125 ++++++++++++
 tb/tb_xtea_iter_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xtea_iter_ctrl.sv
// Iterative XTEA controller: one shared full-round datapath reused for ROUNDS clocks per block,
// with valid/ready handshakes on both the block input and the result output.
module xtea_iter_ctrl #(
    parameter int          ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_decrypt,
    input  logic [63:0]  in_data,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         busy
);

    localparam int          CW      = $clog2(ROUNDS + 1);
    localparam logic [CW-1:0] LAST  = CW'(ROUNDS - 1);
    // Decryption walks the key schedule backwards, starting from the final encrypt sum.
    localparam logic [31:0] SUM_DEC = 32'(DELTA * 32'(ROUNDS));

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [31:0]    v0;
    logic [31:0]    v1;
    logic [31:0]    sum;
    logic [127:0]   key_q;
    logic           dec_q;
    logic           accept;

    logic [31:0]    e_v0;
    logic [31:0]    e_v1;
    logic [31:0]    e_sum;
    logic [31:0]    d_v0;
    logic [31:0]    d_v1;
    logic [31:0]    d_sum;
    logic [31:0]    n_v0;
    logic [31:0]    n_v1;
    logic [31:0]    n_sum;

    function automatic logic [31:0] mix(input logic [31:0] x);
        return ((x << 4) ^ (x >> 5)) + x;
    endfunction

    function automatic logic [31:0] kword(input logic [127:0] k, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = k[127:96];
            2'd1:    w = k[95:64];
            2'd2:    w = k[63:32];
            default: w = k[31:0];
        endcase
        return w;
    endfunction

    // Both half-rounds in one clock; the second half uses the freshly updated word and sum.
    always_comb begin
        e_v0  = v0 + (mix(v1) ^ (sum + kword(key_q, sum[1:0])));
        e_sum = sum + DELTA;
        e_v1  = v1 + (mix(e_v0) ^ (e_sum + kword(key_q, e_sum[12:11])));

        d_v1  = v1 - (mix(v0) ^ (sum + kword(key_q, sum[12:11])));
        d_sum = sum - DELTA;
        d_v0  = v0 - (mix(d_v1) ^ (d_sum + kword(key_q, d_sum[1:0])));

        n_v0  = dec_q ? d_v0  : e_v0;
        n_v1  = dec_q ? d_v1  : e_v1;
        n_sum = dec_q ? d_sum : e_sum;
    end

    assign in_ready  = reset & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (cnt == LAST) state_next = DONE;
            DONE: if (out_ready) state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            v0       <= '0;
            v1       <= '0;
            sum      <= '0;
            key_q    <= '0;
            dec_q    <= 1'b0;
            out_data <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                v0    <= in_data[63:32];
                v1    <= in_data[31:0];
                key_q <= key;
                dec_q <= in_decrypt;
                sum   <= in_decrypt ? SUM_DEC : 32'd0;
                cnt   <= '0;
            end else if (state == RUN) begin
                v0  <= n_v0;
                v1  <= n_v1;
                sum <= n_sum;
                cnt <= cnt + CW'(1);
                if (cnt == LAST) out_data <= {n_v0, n_v1};
            end
        end
    end

endmodule

// File: tb/tb_xtea_iter_ctrl.sv
// Self-checking bench for xtea_iter_ctrl: known answers, randomized blocks against a
// block-level XTEA model, handshake timing, backpressure and reset behaviour.
module tb_xtea_iter_ctrl;

    localparam int          ROUNDS = 32;
    localparam logic [31:0] DELTA  = 32'h9E3779B9;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_decrypt, out_valid, out_ready, busy;
    logic [63:0]  in_data, out_data;
    logic [127:0] key;

    logic         in_valid_1, in_ready_1, in_decrypt_1, out_valid_1, out_ready_1, busy_1;
    logic [63:0]  in_data_1, out_data_1;
    logic [127:0] key_1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xtea_iter_ctrl #(.ROUNDS(ROUNDS), .DELTA(DELTA)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_decrypt(in_decrypt), .in_data(in_data), .key(key), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    xtea_iter_ctrl #(.ROUNDS(1), .DELTA(DELTA)) u_dut_1 (
        .clk(clk), .reset(reset), .in_valid(in_valid_1), .in_ready(in_ready_1),
        .in_decrypt(in_decrypt_1), .in_data(in_data_1), .key(key_1), .out_valid(out_valid_1),
        .out_ready(out_ready_1), .out_data(out_data_1), .busy(busy_1)
    );

    // Reference XTEA in its textbook block form.
    function automatic logic [63:0] xtea_ref(input logic [63:0] blk, input logic [127:0] k,
                                             input logic dec, input int rounds);
        logic [31:0] y, z, s;
        logic [31:0] kw [4];
        y = blk[63:32];
        z = blk[31:0];
        for (int i = 0; i < 4; i++) kw[i] = k[127 - 32*i -: 32];
        if (!dec) begin
            s = 32'd0;
            for (int r = 0; r < rounds; r++) begin
                y = y + ((((z << 4) ^ (z >> 5)) + z) ^ (s + kw[s & 32'd3]));
                s = s + DELTA;
                z = z + ((((y << 4) ^ (y >> 5)) + y) ^ (s + kw[(s >> 11) & 32'd3]));
            end
        end else begin
            s = 32'(DELTA * 32'(rounds));
            for (int r = 0; r < rounds; r++) begin
                z = z - ((((y << 4) ^ (y >> 5)) + y) ^ (s + kw[(s >> 11) & 32'd3]));
                s = s - DELTA;
                y = y - ((((z << 4) ^ (z >> 5)) + z) ^ (s + kw[s & 32'd3]));
            end
        end
        return {y, z};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one block on the 32-round instance; returns at the negedge after the accept edge.
    task automatic applyStimulus(input logic [63:0] data, input logic [127:0] k, input logic dec);
        int n;
        in_valid   = 1'b1;
        in_data    = data;
        key        = k;
        in_decrypt = dec;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        in_valid   = 1'b0;
        in_data    = {$urandom, $urandom};
        key        = {$urandom, $urandom, $urandom, $urandom};
        in_decrypt = 1'($urandom);
    endtask

    // Count cycles to out_valid while scrambling the frozen inputs and toggling out_ready.
    task automatic waitOutput(output int lat);
        logic glitch;
        glitch = 1'b0;
        lat = 0;
        while (!out_valid && lat < ROUNDS + 20) begin
            if (in_ready || !busy) glitch = 1'b1;
            key        = {$urandom, $urandom, $urandom, $urandom};
            in_decrypt = 1'($urandom);
            out_ready  = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b0;
        if (!out_valid) checkOutput("out_timeout", 64'd0, 64'd1);
        checkOutput("run_ready_busy", {63'd0, glitch}, 64'd0);
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("valid_drop", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run1(input logic [63:0] data, input logic dec, output logic [63:0] res,
                        output int lat);
        in_valid_1 = 1'b1;
        in_data_1 = data;
        key_1 = '0;
        in_decrypt_1 = dec;
        checkOutput("r1_in_ready", {63'd0, in_ready_1}, 64'd1);
        @(negedge clk);
        in_valid_1 = 1'b0;
        lat = 0;
        while (!out_valid_1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        res = out_data_1;
        out_ready_1 = 1'b1;
        @(negedge clk);
        out_ready_1 = 1'b0;
    endtask

    initial begin
        logic [63:0]  res, d, a, b, exp;
        logic [127:0] k, ka, kb;
        logic         dec, seen;
        int           lat, hold, sp;

        reset = 1'b0;
        in_valid = 0; in_decrypt = 0; in_data = '0; key = '0; out_ready = 0;
        in_valid_1 = 0; in_decrypt_1 = 0; in_data_1 = '0; key_1 = '0; out_ready_1 = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_out_data", out_data, 64'd0);
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // Known answer, latency, and key-port changes during RUN.
        applyStimulus(64'd0, 128'd0, 1'b0);
        waitOutput(lat);
        checkOutput("lat32", 64'(lat), 64'(ROUNDS));
        checkOutput("enc32_kat", out_data, 64'hDEE9D4D8_F7131ED9);
        checkOutput("done_busy", {63'd0, busy}, 64'd1);
        res = out_data;
        retire();
        applyStimulus(res, 128'd0, 1'b1);
        waitOutput(lat);
        checkOutput("dec32_kat", out_data, 64'd0);
        retire();

        // Randomized blocks with short random backpressure.
        for (int i = 0; i < 6; i++) begin
            d   = {$urandom, $urandom};
            k   = {$urandom, $urandom, $urandom, $urandom};
            dec = 1'($urandom);
            applyStimulus(d, k, dec);
            waitOutput(lat);
            res = out_data;
            hold = $urandom_range(0, 3);
            repeat (hold) begin
                @(negedge clk);
                checkOutput("hold_stable", out_data, res);
            end
            checkOutput("rand_block", out_data, xtea_ref(d, k, dec, ROUNDS));
            retire();
        end

        // Ten cycles of backpressure in DONE.
        d = {$urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(d, k, 1'b0);
        waitOutput(lat);
        exp = xtea_ref(d, k, 1'b0, ROUNDS);
        repeat (10) begin
            @(negedge clk);
            checkOutput("bp_valid", {63'd0, out_valid}, 64'd1);
            checkOutput("bp_data", out_data, exp);
            checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        retire();
        @(negedge clk);
        checkOutput("bp_single", {63'd0, out_valid}, 64'd0);

        // Back-to-back: in_valid held, second block accepted while the first retires.
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = a; key = ka; in_decrypt = 1'b0;
        @(negedge clk);
        in_data = b; key = kb; in_decrypt = 1'b1;
        seen = 1'b0;
        sp = 0;
        while (!out_valid && sp < 100) begin
            if (in_ready) seen = 1'b1;
            @(negedge clk);
            sp++;
        end
        checkOutput("b2b_no_glitch", {63'd0, seen}, 64'd0);
        checkOutput("b2b_first", out_data, xtea_ref(a, ka, 1'b0, ROUNDS));
        checkOutput("b2b_ready_done", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("b2b_gap_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("b2b_gap_busy", {63'd0, busy}, 64'd1);
        sp = 1;
        while (!out_valid && sp < 100) begin
            @(negedge clk);
            sp++;
        end
        checkOutput("b2b_spacing", 64'(sp), 64'(ROUNDS + 1));
        checkOutput("b2b_second", out_data, xtea_ref(b, kb, 1'b1, ROUNDS));
        retire();

        // Reset in the middle of RUN discards the block.
        applyStimulus({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        repeat (15) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rr_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rr_busy", {63'd0, busy}, 64'd0);
        checkOutput("rr_in_ready_low", {63'd0, in_ready}, 64'd0);
        reset = 1'b1;
        #1;
        checkOutput("rr_in_ready", {63'd0, in_ready}, 64'd1);
        seen = 1'b0;
        repeat (ROUNDS + 5) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("rr_no_output", {63'd0, seen}, 64'd0);

        // Reset while the result is waiting in DONE drops it.
        applyStimulus({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        waitOutput(lat);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rd_valid", {63'd0, out_valid}, 64'd0);
        reset = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("rd_no_output", {63'd0, seen}, 64'd0);

        // Single-round instance.
        run1(64'd0, 1'b0, res, lat);
        checkOutput("r1_lat", 64'(lat), 64'd1);
        checkOutput("r1_enc", res, 64'h00000000_9E3779B9);
        run1(64'h00000000_9E3779B9, 1'b1, res, lat);
        checkOutput("r1_dec", res, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
